// File: rtl/adc_spi_responder.sv
// ----------------------------------------------------------------------------
// adc_spi_responder
// Behavioural stand-in for an SPI-read ADC. A rising edge on cnv starts a
// conversion. The conversion returns the sample offered on the AXI-Stream
// slave port. The word is then shifted out on 1, 2 or 4 SPI lanes, MSB first.
// An SPI command path handles register-access mode and lane-mode selection.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   cnv                 conversion start pin (async, rising edge)
//   busy                high for CNV_CYCLES cycles while converting
//   spi_sck/csn/sdi     SPI initiator pins (async)
//   spi_sdo[3:0]        readout lanes
//   s_axis_tdata/tvalid sample returned by the next conversion
//   s_axis_tready       one-cycle pulse when a sample is taken
//   lane_mode           00 one lane, 01 two lanes, 10 four lanes
//   reg_access          high while in register-access mode
//   underflow           sticky: no sample was available at conversion start
// ----------------------------------------------------------------------------
module adc_spi_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNV_CYCLES = 28
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cnv,
  output logic                  busy,
  input  logic                  spi_sck,
  input  logic                  spi_csn,
  input  logic                  spi_sdi,
  output logic [3:0]            spi_sdo,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [1:0]            lane_mode,
  output logic                  reg_access,
  output logic                  underflow
);

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned PTR_W     = 6;
  localparam int unsigned CMD_W     = 24;
  localparam int unsigned CMD_CNT_W = 5;
  localparam int unsigned SYNC_W    = 4;
  localparam int unsigned ARM_W     = 2;

  localparam logic [15:0] LANE_ADDR = {1'b1, 15'h0020};
  localparam logic [15:0] EXIT_ADDR = {1'b1, 15'h0014};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_READY   = 2'd2
  } state_e;

  state_e                 state_q, state_d;

  // Synchronizer bit order: 0 cnv, 1 sck, 2 csn, 3 sdi
  logic [SYNC_W-1:0]      sync1_q, sync1_d;
  logic [SYNC_W-1:0]      sync2_q, sync2_d;
  logic [2:0]             prev_q, prev_d;
  logic [ARM_W-1:0]       arm_q, arm_d;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [PTR_W-1:0]       bits_left_q, bits_left_d;
  logic                   rd_active_q, rd_active_d;
  logic [3:0]             sdo_q, sdo_d;
  logic                   busy_q, busy_d;
  logic                   tready_q, tready_d;
  logic                   underflow_q, underflow_d;

  logic [CMD_W-1:0]       cmd_q, cmd_d;
  logic [CMD_CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [1:0]             lane_q, lane_d;
  logic                   reg_access_q, reg_access_d;

  logic edge_en, cnv_rise, sck_rise, sck_fall, csn_rise, csn_fall, csn_low, sdi_s;
  logic start_cnv, conv_done, present;

  // Edges are masked until both synchronizer stages and the history flop hold
  // real pin values, so a level already present at reset release is not an edge.
  always_comb begin
    sync1_d  = {spi_sdi, spi_csn, spi_sck, cnv};
    sync2_d  = sync1_q;
    prev_d   = sync2_q[2:0];
    arm_d    = (arm_q == '1) ? arm_q : arm_q + ARM_W'(1);
    edge_en  = (arm_q == '1);
    cnv_rise = edge_en &  sync2_q[0] & ~prev_q[0];
    sck_rise = edge_en &  sync2_q[1] & ~prev_q[1];
    sck_fall = edge_en & ~sync2_q[1] &  prev_q[1];
    csn_rise = edge_en &  sync2_q[2] & ~prev_q[2];
    csn_fall = edge_en & ~sync2_q[2] &  prev_q[2];
    csn_low  = ~sync2_q[2];
    sdi_s    = sync2_q[3];
  end

  // State register and all datapath flops
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      arm_q        <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      shift_q      <= '0;
      bits_left_q  <= '0;
      rd_active_q  <= 1'b0;
      sdo_q        <= '0;
      busy_q       <= 1'b0;
      tready_q     <= 1'b0;
      underflow_q  <= 1'b0;
      cmd_q        <= '0;
      cmd_cnt_q    <= '0;
      lane_q       <= '0;
      reg_access_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      arm_q        <= arm_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      shift_q      <= shift_d;
      bits_left_q  <= bits_left_d;
      rd_active_q  <= rd_active_d;
      sdo_q        <= sdo_d;
      busy_q       <= busy_d;
      tready_q     <= tready_d;
      underflow_q  <= underflow_d;
      cmd_q        <= cmd_d;
      cmd_cnt_q    <= cmd_cnt_d;
      lane_q       <= lane_d;
      reg_access_q <= reg_access_d;
    end
  end

  // Conversion FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cnv_rise && !reg_access_q) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        if (cnt_q == '0) state_d = S_READY;
      end
      S_READY: begin
        // A new conversion discards the unread word
        if (cnv_rise && !reg_access_q)                          state_d = S_CONVERT;
        else if (rd_active_q && csn_rise)                       state_d = S_IDLE;
        else if (rd_active_q && sck_fall && bits_left_q == '0)  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Conversion FSM outputs and readout shifter
  always_comb begin
    busy_d      = busy_q;
    tready_d    = 1'b0;
    underflow_d = underflow_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    rd_active_d = rd_active_q;
    sdo_d       = sdo_q;
    present     = 1'b0;
    start_cnv   = (state_d == S_CONVERT) && (state_q != S_CONVERT);
    conv_done   = (state_q == S_CONVERT) && (state_d == S_READY);

    if (start_cnv) begin
      busy_d      = 1'b1;
      cnt_d       = CNT_W'(CNV_CYCLES - 1);
      rd_active_d = 1'b0;
      sdo_d       = '0;
      shift_d     = '0;
      bits_left_d = '0;
      if (s_axis_tvalid) begin
        word_d   = s_axis_tdata;
        tready_d = 1'b1;
      end else begin
        word_d      = '0;
        underflow_d = 1'b1;
      end
    end else if (state_q == S_CONVERT) begin
      if (conv_done) begin
        busy_d      = 1'b0;
        shift_d     = word_q;
        bits_left_d = PTR_W'(DATA_WIDTH);
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (state_q == S_READY) begin
      if (state_d == S_IDLE) begin
        rd_active_d = 1'b0;
        sdo_d       = '0;
      end else if (rd_active_q && sck_fall) begin
        present = 1'b1;
      end else if (!rd_active_q && csn_fall && !reg_access_q) begin
        rd_active_d = 1'b1;
        present     = 1'b1;
      end
    end

    // Present the next group; the group MSB goes on the highest used lane
    if (present) begin
      case (lane_q)
        2'b01: begin
          sdo_d       = {2'b00, shift_q[DATA_WIDTH-1 -: 2]};
          shift_d     = shift_q << 2;
          bits_left_d = bits_left_q - PTR_W'(2);
        end
        2'b10: begin
          sdo_d       = shift_q[DATA_WIDTH-1 -: 4];
          shift_d     = shift_q << 4;
          bits_left_d = bits_left_q - PTR_W'(4);
        end
        default: begin
          sdo_d       = {3'b000, shift_q[DATA_WIDTH-1]};
          shift_d     = shift_q << 1;
          bits_left_d = bits_left_q - PTR_W'(1);
        end
      endcase
    end
  end

  // Command capture and decode; runs in every frame regardless of readout
  always_comb begin
    cmd_d        = cmd_q;
    cmd_cnt_d    = cmd_cnt_q;
    lane_d       = lane_q;
    reg_access_d = reg_access_q;

    if (csn_fall) begin
      cmd_d     = '0;
      cmd_cnt_d = '0;
    end else if (sck_rise && csn_low && cmd_cnt_q != CMD_CNT_W'(CMD_W)) begin
      cmd_d     = {cmd_q[CMD_W-2:0], sdi_s};
      cmd_cnt_d = cmd_cnt_q + CMD_CNT_W'(1);
    end

    // Only frames of exactly 24 bits are decoded
    if (csn_rise && cmd_cnt_q == CMD_CNT_W'(CMD_W)) begin
      if (cmd_q[23:21] == 3'b101) begin
        reg_access_d = 1'b1;
      end else if (reg_access_q && cmd_q[23:8] == LANE_ADDR) begin
        if (cmd_q[7:6] != 2'b11) lane_d = cmd_q[7:6];
      end else if (reg_access_q && cmd_q[23:8] == EXIT_ADDR && cmd_q[0]) begin
        reg_access_d = 1'b0;
      end
    end
  end

  assign busy          = busy_q;
  assign spi_sdo       = sdo_q;
  assign s_axis_tready = tready_q;
  assign lane_mode     = lane_q;
  assign reg_access    = reg_access_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// ----------------------------------------------------------------------------
// tb_adc_spi_responder
// Self-checking bench: directed scenarios followed by randomized conversion /
// lane-mode / readout rounds. Expectations come from a small model of the
// visible ADC behaviour (current word, lane mode, register mode, underflow).
// ----------------------------------------------------------------------------
module tb_adc_spi_responder;

  localparam int unsigned CNV  = 28;
  localparam int          HALF = 6;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cnv;
  logic        busy;
  logic        spi_sck;
  logic        spi_csn;
  logic        spi_sdi;
  logic [3:0]  spi_sdo;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [1:0]  lane_mode;
  logic        reg_access;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [1:0]  m_lane;
  logic        m_reg;
  logic        m_uf;
  logic [31:0] m_word;

  adc_spi_responder #(.DATA_WIDTH(32), .CNV_CYCLES(CNV)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cnv           (cnv),
    .busy          (busy),
    .spi_sck       (spi_sck),
    .spi_csn       (spi_csn),
    .spi_sdi       (spi_sdi),
    .spi_sdo       (spi_sdo),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .lane_mode     (lane_mode),
    .reg_access    (reg_access),
    .underflow     (underflow)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lanes(input logic [1:0] m);
    return (m == 2'b10) ? 4 : ((m == 2'b01) ? 2 : 1);
  endfunction

  // Group i of word w when read k bits at a time, MSB first
  function automatic logic [3:0] exp_group(input logic [31:0] w, input int k, input int i);
    logic [31:0] t;
    t = w >> (32 - k * (i + 1));
    return 4'(t & ((32'd1 << k) - 32'd1));
  endfunction

  function automatic void model_cmd(input logic [23:0] c, input int n);
    if (n != 24) return;
    if (c[23:21] == 3'b101) m_reg = 1'b1;
    else if (m_reg && c[23:8] == 16'h8020) begin
      if (c[7:6] != 2'b11) m_lane = c[7:6];
    end else if (m_reg && c[23:8] == 16'h8014 && c[0]) m_reg = 1'b0;
  endfunction

  task automatic spi_cmd(input logic [23:0] c, input int n);
    spi_csn = 1'b0;
    repeat (HALF) @(negedge aclk);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi = c[i];
      repeat (HALF) @(negedge aclk);
      spi_sck = 1'b1;
      repeat (HALF) @(negedge aclk);
      spi_sck = 1'b0;
    end
    repeat (HALF) @(negedge aclk);
    spi_csn = 1'b1;
    spi_sdi = 1'b0;
    repeat (HALF) @(negedge aclk);
    model_cmd(c, n);
    check($sformatf("cmd %06h lane_mode", c), 32'(lane_mode), 32'(m_lane));
    check($sformatf("cmd %06h reg_access", c), 32'(reg_access), 32'(m_reg));
  endtask

  task automatic convert(input logic [31:0] d, input logic v, input string tag);
    int  busy_cnt;
    int  rdy_cnt;
    logic done;
    busy_cnt = 0;
    rdy_cnt  = 0;
    done     = 1'b0;
    s_axis_tdata  = d;
    s_axis_tvalid = v;
    cnv = 1'b1;
    for (int c = 0; c < int'(CNV) + 40 && !done; c++) begin
      @(negedge aclk);
      if (busy) busy_cnt++;
      if (s_axis_tready) rdy_cnt++;
      if (busy_cnt > 0 && !busy) done = 1'b1;
    end
    cnv = 1'b0;
    s_axis_tvalid = 1'b0;
    if (m_reg) begin
      check({tag, " ignored busy"}, 32'(busy_cnt), 32'd0);
      check({tag, " ignored tready"}, 32'(rdy_cnt), 32'd0);
    end else begin
      m_word = v ? d : 32'h0;
      if (!v) m_uf = 1'b1;
      check({tag, " busy done"}, 32'(done), 32'd1);
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'(CNV));
      check({tag, " tready pulses"}, 32'(rdy_cnt), v ? 32'd1 : 32'd0);
    end
    check({tag, " underflow"}, 32'(underflow), 32'(m_uf));
    repeat (4) @(negedge aclk);
  endtask

  task automatic readout(input int nsck, input string tag);
    int k;
    int g;
    logic [31:0] asm_w;
    logic [3:0]  eg;
    k = lanes(m_lane);
    g = 32 / k;
    asm_w = 32'h0;
    spi_csn = 1'b0;
    repeat (HALF) @(negedge aclk);
    for (int i = 0; i < nsck; i++) begin
      spi_sck = 1'b1;
      repeat (HALF) @(negedge aclk);
      eg = (i < g) ? exp_group(m_word, k, i) : 4'h0;
      check($sformatf("%s group %0d", tag, i), 32'(spi_sdo), 32'(eg));
      if (i < g) asm_w = (asm_w << k) | 32'(spi_sdo);
      spi_sck = 1'b0;
      repeat (HALF) @(negedge aclk);
    end
    if (nsck >= g) check({tag, " word"}, asm_w, m_word);
    eg = (nsck < g) ? exp_group(m_word, k, nsck) : 4'h0;
    check({tag, " after last fall"}, 32'(spi_sdo), 32'(eg));
    spi_csn = 1'b1;
    repeat (HALF) @(negedge aclk);
    check({tag, " sdo after csn"}, 32'(spi_sdo), 32'h0);
    model_cmd(24'h0, (nsck >= 24) ? 24 : nsck);
  endtask

  task automatic set_lane(input logic [1:0] lm);
    spi_cmd(24'hA00000, 24);
    spi_cmd({16'h8020, lm, 6'h00}, 24);
    spi_cmd(24'h801401, 24);
  endtask

  initial begin
    areset = 1'b1;
    cnv = 1'b0; spi_sck = 1'b0; spi_csn = 1'b1; spi_sdi = 1'b0;
    s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0;
    m_lane = 2'b00; m_reg = 1'b0; m_uf = 1'b0; m_word = 32'h0;
    repeat (3) @(negedge aclk);
    check("reset busy", 32'(busy), 32'h0);
    check("reset sdo", 32'(spi_sdo), 32'h0);
    check("reset tready", 32'(s_axis_tready), 32'h0);
    check("reset lane_mode", 32'(lane_mode), 32'h0);
    check("reset reg_access", 32'(reg_access), 32'h0);
    check("reset underflow", 32'(underflow), 32'h0);
    areset = 1'b0;
    repeat (8) @(negedge aclk);

    // One-lane readout with two surplus clocks
    convert(32'h8BADF00D, 1'b1, "c1");
    readout(34, "r1");

    // Four-lane mode
    set_lane(2'b10);
    convert(32'h8BADF00D, 1'b1, "c2");
    readout(8, "r2");

    // Two-lane mode
    set_lane(2'b01);
    convert(32'h0023FF42, 1'b1, "c3");
    readout(16, "r3");

    // Missing sample, register mode ignores cnv, short frame is ignored
    convert(32'hDEADBEEF, 1'b0, "c4");
    readout(16, "r4");
    spi_cmd(24'hA00000, 24);
    convert(32'h12345678, 1'b1, "c4reg");
    spi_cmd(24'h080208, 20);
    spi_cmd(24'h801401, 24);

    // Aborted one-lane readout then a fresh conversion
    set_lane(2'b00);
    convert(32'h8BADF00D, 1'b1, "c5");
    readout(10, "r5abort");
    convert(32'h0023FF42, 1'b1, "c5b");
    readout(33, "r5b");

    // Reset in the middle of a four-lane conversion
    set_lane(2'b10);
    s_axis_tdata = 32'hCAFEF00D; s_axis_tvalid = 1'b1; cnv = 1'b1;
    repeat (12) @(negedge aclk);
    check("mid-convert busy", 32'(busy), 32'h1);
    #2 areset = 1'b1;
    #1;
    check("async reset busy", 32'(busy), 32'h0);
    check("async reset lane_mode", 32'(lane_mode), 32'h0);
    check("async reset underflow", 32'(underflow), 32'h0);
    check("async reset reg_access", 32'(reg_access), 32'h0);
    m_lane = 2'b00; m_reg = 1'b0; m_uf = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    // cnv is still high at release: no conversion may start
    repeat (12) @(negedge aclk);
    check("stale cnv after reset", 32'(busy), 32'h0);
    cnv = 1'b0;
    repeat (4) @(negedge aclk);
    convert(32'hA5C3_0F96, 1'b1, "c6");
    readout(33, "r6");

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin : rnd
      logic [1:0]  lm;
      logic [31:0] d;
      logic        v;
      int          g;
      lm = 2'($urandom_range(0, 3));
      set_lane(lm);
      d = $urandom;
      v = ($urandom_range(0, 4) != 0);
      convert(d, v, $sformatf("rc%0d", r));
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom;
        convert(d, 1'b1, $sformatf("rc%0d restart", r));
      end
      g = 32 / lanes(m_lane);
      readout($urandom_range(1, g + 1), $sformatf("rr%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 Parameter DATA_WIDTH, 32, conversion word width; fixed at 32.
REQ-002 Parameter CNV_CYCLES, 28, busy duration in aclk cycles; legal range 2..1023.
REQ-003 aclk  in  1  single clock; all state on rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 cnv  in  1  conversion start (asynchronous pin), rising edge significant.
REQ-006 busy  out  1  high while converting.
REQ-007 spi_sck  in  1  SPI clock from initiator (asynchronous pin).
REQ-008 spi_csn  in  1  chip select, active low (asynchronous pin).
REQ-009 spi_sdi  in  1  command data from initiator.
REQ-010 spi_sdo  out  4  readout lanes; lane 0 only in one-lane mode.
REQ-011 s_axis_tdata  in  32  sample to be returned by the next conversion.
REQ-012 s_axis_tvalid  in  1  sample valid.
REQ-013 s_axis_tready  out  1  one-cycle accept pulse.
REQ-014 lane_mode  out  2  current lane mode: 00 one, 01 two, 10 four.
REQ-015 reg_access  out  1  high while in register-access mode.
REQ-016 underflow  out  1  sticky; sample missing at conversion start.

Function
REQ-017 cnv, spi_sck, spi_csn, spi_sdi pass through 2-FF synchronizers; edges detected on synchronized copies; spi_sck high/low times of at least 4 aclk cycles are required.
REQ-018 Conversion FSM states IDLE, CONVERT, READY; reset state IDLE.
REQ-019 Synchronized cnv rise in IDLE or READY with reg_access=0 -> CONVERT; busy=1 next cycle; busy stays high exactly CNV_CYCLES cycles.
REQ-020 On entry to CONVERT: if s_axis_tvalid=1, latch s_axis_tdata, pulse s_axis_tready one cycle; else latch 0 and set underflow.
REQ-021 cnv rise in CONVERT is ignored; cnv rise in READY discards the unread word and restarts conversion.
REQ-022 CONVERT counter expiry -> busy=0, READY, shift register loaded with latched word, bit pointer = 32.
REQ-023 Readout only when READY, reg_access=0, spi_csn low; groups of k=1/2/4 bits per lane_mode, MSB first, MSB of group on highest used lane.
REQ-024 Synchronized csn fall presents first group on spi_sdo; each synchronized sck fall presents next group; initiator samples on sck rise.
REQ-025 After 32/k groups presented, the next sck fall -> IDLE and spi_sdo=0; extra sck edges drive 0.
REQ-026 csn rise during readout -> IDLE, remaining bits discarded, spi_sdo=0.
REQ-027 Unused lanes and all lanes outside readout drive 0.
REQ-028 Command path: csn fall clears 24-bit command register and 5-bit bit counter; each sck rise with csn low shifts spi_sdi in LSB first-position (MSB-first transfer), counter saturates at 24.
REQ-029 On csn rise with counter exactly 24: cmd[23:21]=101 -> reg_access=1; else if reg_access and cmd[23:8]=={1,15'h0020} -> lane_mode=cmd[7:6] unless cmd[7:6]=11 (ignored); else if reg_access and cmd[23:8]=={1,15'h0014} and cmd[0]=1 -> reg_access=0.
REQ-030 Counter not 24 at csn rise -> command ignored, no state change.
REQ-031 Command decode and readout in the same frame are independent; commands are decoded in conversion mode too.
REQ-032 underflow clears only on reset.

Reset
REQ-033 areset asserted: busy=0, spi_sdo=0, s_axis_tready=0, lane_mode=00, reg_access=0, underflow=0, FSM IDLE, counters and shift registers 0, synchronizers cleared; effective immediately, including mid-conversion or mid-frame.
REQ-034 After areset release, a cnv edge or csn edge already present at release does not trigger an action.

Verification
REQ-035 tdata=8BADF00D valid, cnv pulse -> tready 1 cycle, busy high CNV_CYCLES cycles; 32 sck in one-lane -> sdo[0] bits = 8BADF00D, underflow=0.
REQ-036 Frames A00000, 802080, 801401 (24 sck each) -> reg_access 1 then 0, lane_mode=10; conversion of 8BADF00D with 8 sck -> nibbles 8,B,A,D,F,0,0,D.
REQ-037 Frames A00000, 802040, 801401; tdata 0023FF42, 16 sck -> 2-bit groups = 0023FF42.
REQ-038 tvalid=0 at cnv -> readout all zero, underflow=1, tready never pulses; 20-bit frame 80208 -> lane_mode unchanged.
REQ-039 csn high after 10 bits of 8BADF00D -> sdo=0; new cnv with 0023FF42 -> full 32-bit 0023FF42.
REQ-040 areset mid-CONVERT with lane_mode=10 -> busy=0 and lane_mode=00 before next aclk edge; following cnv works in one-lane mode.
